// File: rtl/score_pkg.sv
// Shared types and constants for the score digit feeder: points table,
// default sizes, glyph geometry and the conversion FSM states.
package score_pkg;

    localparam int DIGITS_DEF  = 4;
    localparam int SCORE_W_DEF = 14;
    localparam int SCORE_MAX   = 10 ** DIGITS_DEF - 1;

    // Glyph geometry in cells: 3 lit columns plus one gap column per digit.
    localparam int CELL_W  = 4;
    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [3:0] line_points(input logic [2:0] lines);
        case (lines)
            3'd1:    return 4'd1;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            3'd4:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. One conversion is
// LOAD + BIN_W SHIFT cycles + COMMIT; done is high during COMMIT.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int BIN_W  = SCORE_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t              state_q, state_d;
    logic [BCD_W+BIN_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]         adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (sr_q[BIN_W + 4*i +: 4] >= 4'd5) ?
                            sr_q[BIN_W + 4*i +: 4] + 4'd3 :
                            sr_q[BIN_W + 4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sr_d    = {{BCD_W{1'b0}}, bin};
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_d  = {adj, sr_q[BIN_W-1:0]} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd  = sr_q[BIN_W +: BCD_W];
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_COMMIT);

endmodule

// File: rtl/score_digit_feeder.sv
// Score register, BCD conversion requests and per-pixel digit/glyph decode.
// Define SCORE_BLANK_LEADING_ZERO_EN to blank leading-zero digits.
module score_digit_feeder
    import score_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEF,
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int ORIGIN_X   = 400,
    parameter int ORIGIN_Y   = 40,
    parameter int SCALE_LOG2 = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               add_valid,
    input  logic [2:0]         lines_cleared,
    input  logic               clear_score,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic [3:0]         digit,
    output logic [2:0]         glyph_x,
    output logic [2:0]         glyph_y,
    output logic               in_digit
);

    localparam int BCD_W     = 4 * DIGITS;
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CELL_LOG2 = $clog2(CELL_W);
    localparam logic [SCORE_W:0] MAX_V = (SCORE_W + 1)'(10 ** DIGITS - 1);

    logic [SCORE_W-1:0] score_q, score_d;
    logic               pending_q, pending_d;
    logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
    logic [3:0]         pts;
    logic [SCORE_W:0]   sum;
    logic               changed;
    logic               conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    logic [3:0]         digit_q, digit_d;
    logic [2:0]         glyph_x_q, glyph_x_d;
    logic [2:0]         glyph_y_q, glyph_y_d;
    logic               in_digit_q, in_digit_d;
    logic [9:0]         dx, dy, u, v;
    logic               in_field;
    logic [IDX_W-1:0]   idx;

    bin2bcd_seq #(
        .BIN_W  (SCORE_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score_q),
        .bcd   (conv_bcd),
        .busy  (conv_busy),
        .done  (conv_done)
    );

    always_comb begin
        pts     = line_points(lines_cleared);
        sum     = {1'b0, score_q} + {{(SCORE_W - 3){1'b0}}, pts};
        score_d = score_q;
        changed = 1'b0;
        if (clear_score) begin
            score_d = '0;
            changed = 1'b1;
        end else if (add_valid && pts != 4'd0) begin
            score_d = (sum > MAX_V) ? MAX_V[SCORE_W-1:0] : sum[SCORE_W-1:0];
            changed = 1'b1;
        end
        // A change during a conversion re-arms pending so a fresh pass follows.
        conv_start = pending_q && !conv_busy;
        pending_d  = pending_q;
        if (conv_start) pending_d = 1'b0;
        if (changed)    pending_d = 1'b1;
        disp_bcd_d = conv_done ? conv_bcd : disp_bcd_q;
    end

`ifdef SCORE_BLANK_LEADING_ZERO_EN
    localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'((1 << (DIGITS - 1)) - 1);
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              lead;

    // Mask bit i (0 = leftmost) is set while every digit up to i is zero.
    always_comb begin
        blank_d = blank_q;
        lead    = 1'b1;
        if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (conv_bcd[4*(DIGITS-1-i) +: 4] != 4'd0) lead = 1'b0;
                blank_d[i] = lead && (i != DIGITS - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) blank_q <= BLANK_RST;
        else       blank_q <= blank_d;
    end
`endif

    always_comb begin
        dx       = pix_x - 10'(ORIGIN_X);
        dy       = pix_y - 10'(ORIGIN_Y);
        u        = dx >> SCALE_LOG2;
        v        = dy >> SCALE_LOG2;
        in_field = (pix_x >= 10'(ORIGIN_X)) && (pix_y >= 10'(ORIGIN_Y)) &&
                   (u < 10'(CELL_W * DIGITS)) && (v < 10'(GLYPH_H));
        idx      = IDX_W'(u >> CELL_LOG2);

        digit_d    = 4'd0;
        glyph_x_d  = 3'd0;
        glyph_y_d  = 3'd0;
        in_digit_d = 1'b0;
        if (in_field) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IDX_W'(i)) digit_d = disp_bcd_q[4*(DIGITS-1-i) +: 4];
            end
            glyph_x_d  = 3'(u[CELL_LOG2-1:0]);
            glyph_y_d  = v[2:0];
            in_digit_d = (glyph_x_d < 3'(GLYPH_W));
`ifdef SCORE_BLANK_LEADING_ZERO_EN
            if (blank_q[idx]) in_digit_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q    <= '0;
            pending_q  <= 1'b0;
            disp_bcd_q <= '0;
            digit_q    <= 4'd0;
            glyph_x_q  <= 3'd0;
            glyph_y_q  <= 3'd0;
            in_digit_q <= 1'b0;
        end else begin
            score_q    <= score_d;
            pending_q  <= pending_d;
            disp_bcd_q <= disp_bcd_d;
            digit_q    <= digit_d;
            glyph_x_q  <= glyph_x_d;
            glyph_y_q  <= glyph_y_d;
            in_digit_q <= in_digit_d;
        end
    end

    assign score    = score_q;
    assign busy     = conv_busy;
    assign digit    = digit_q;
    assign glyph_x  = glyph_x_q;
    assign glyph_y  = glyph_y_q;
    assign in_digit = in_digit_q;

endmodule

// File: tb/tb_score_digit_feeder.sv
// Randomized bench for score_digit_feeder with a decimal-arithmetic reference
// model compared every cycle, plus hand-computed literal checks.
module tb_score_digit_feeder;

    localparam int OX = 400;
    localparam int OY = 40;
    localparam int MAXS = 9999;
    localparam int CONV_CYC = 16;
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        add_valid = 1'b0;
    logic [2:0]  lines_cleared = 3'd0;
    logic        clear_score = 1'b0;
    logic [9:0]  pix_x = 10'd0;
    logic [9:0]  pix_y = 10'd0;
    logic [13:0] score;
    logic        busy;
    logic [3:0]  digit;
    logic [2:0]  glyph_x;
    logic [2:0]  glyph_y;
    logic        in_digit;

    int total = 0;
    int bad = 0;

    score_digit_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .add_valid     (add_valid),
        .lines_cleared (lines_cleared),
        .clear_score   (clear_score),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .score         (score),
        .busy          (busy),
        .digit         (digit),
        .glyph_x       (glyph_x),
        .glyph_y       (glyph_y),
        .in_digit      (in_digit)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int pts_of(input int l);
        case (l)
            1: return 1;
            2: return 3;
            3: return 5;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit f_field(input int px, input int py);
        return (px >= OX) && (py >= OY) && ((px - OX) / 8 < 16) && ((py - OY) / 8 < 5);
    endfunction

    function automatic int f_dig(input int px, input int py, input int disp);
        if (!f_field(px, py)) return 0;
        return (disp / p10(3 - (px - OX) / 32)) % 10;
    endfunction

    function automatic int f_gx(input int px, input int py);
        return f_field(px, py) ? ((px - OX) / 8) % 4 : 0;
    endfunction

    function automatic int f_gy(input int px, input int py);
        return f_field(px, py) ? (py - OY) / 8 : 0;
    endfunction

    function automatic bit f_in(input int px, input int py, input int disp);
        int di;
        if (!f_field(px, py)) return 1'b0;
        if (((px - OX) / 8) % 4 == 3) return 1'b0;
        di = (px - OX) / 32;
        if (BLANK && di < 3 && disp < p10(3 - di)) return 1'b0;
        return 1'b1;
    endfunction

    int m_score = 0, m_phase = 0, m_snap = 0, m_disp = 0;
    bit m_pending = 1'b0;
    int m_dig = 0, m_gx = 0, m_gy = 0;
    bit m_in = 1'b0;
    bit chg;

    assign chg = clear_score || (add_valid && pts_of(int'(lines_cleared)) != 0);

    // m_phase counts cycles into a conversion: 1 = snapshot, CONV_CYC = commit.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_score <= 0; m_phase <= 0; m_snap <= 0; m_disp <= 0; m_pending <= 1'b0;
            m_dig <= 0; m_gx <= 0; m_gy <= 0; m_in <= 1'b0;
        end else begin
            if (clear_score) m_score <= 0;
            else if (add_valid)
                m_score <= (m_score + pts_of(int'(lines_cleared)) > MAXS) ? MAXS :
                           m_score + pts_of(int'(lines_cleared));
            m_pending <= chg ? 1'b1 : ((m_phase == 0 && m_pending) ? 1'b0 : m_pending);
            if (m_phase == 0) m_phase <= m_pending ? 1 : 0;
            else m_phase <= (m_phase == CONV_CYC) ? 0 : m_phase + 1;
            if (m_phase == 1) m_snap <= m_score;
            if (m_phase == CONV_CYC) m_disp <= m_snap;
            m_dig <= f_dig(int'(pix_x), int'(pix_y), m_disp);
            m_gx  <= f_gx(int'(pix_x), int'(pix_y));
            m_gy  <= f_gy(int'(pix_x), int'(pix_y));
            m_in  <= f_in(int'(pix_x), int'(pix_y), m_disp);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (score !== 14'(m_score) || busy !== (m_phase != 0) ||
                digit !== 4'(m_dig) || glyph_x !== 3'(m_gx) ||
                glyph_y !== 3'(m_gy) || in_digit !== m_in) begin
                bad++;
                $display("FAIL model_cmp t=%0t got score=%0d busy=%0b dig=%0d gx=%0d gy=%0d in=%0b want score=%0d busy=%0b dig=%0d gx=%0d gy=%0d in=%0b",
                         $time, score, busy, digit, glyph_x, glyph_y, in_digit,
                         m_score, m_phase != 0, m_dig, m_gx, m_gy, m_in);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int l);
        add_valid = 1'b1;
        lines_cleared = 3'(l);
        tick();
        add_valid = 1'b0;
    endtask

    task automatic clr();
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
    endtask

    task automatic set_pix(input int u, input int v);
        pix_x = 10'(OX + u * 8);
        pix_y = 10'(OY + v * 8);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((m_phase != 0 || m_pending) && n < 300) begin
            tick();
            n++;
        end
        chk("quiet_timeout", int'(m_phase != 0 || m_pending), 0);
        chk("quiet_busy", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int odd;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_score", int'(score), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_digit", int'(in_digit), 0);

        // points and conversion latency
        add(4); wait_quiet();
        add(4); wait_quiet();
        set_pix(12, 0);
        add(4);
        chk("score_24", int'(score), 24);
        repeat (17) tick();
        chk("units_before_commit", int'(digit), 6);
        tick();
        chk("units_after_commit", int'(digit), 4);
        set_pix(8, 0); tick();
        chk("tens_24", int'(digit), 2);
        wait_quiet();

        // saturation
        clr();
        add_valid = 1'b1; lines_cleared = 3'd4;
        repeat (1249) tick();
        lines_cleared = 3'd2; tick();
        add_valid = 1'b0;
        chk("score_9995", int'(score), 9995);
        add(4);
        chk("score_sat", int'(score), 9999);
        add(4);
        chk("score_sat_hold", int'(score), 9999);
        wait_quiet();
        for (int i = 0; i < 4; i++) begin
            set_pix(4 * i, 1); tick();
            chk("sat_digit_9", int'(digit), 9);
        end

        // coalescing
        clr(); wait_quiet();
        set_pix(12, 0); tick();
        add(1);
        repeat (4) tick();
        chk("busy_mid_conv", int'(busy), 1);
        add(2);
        odd = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!(digit inside {4'd0, 4'd1, 4'd4})) odd++;
        end
        chk("coalesce_no_intermediate", odd, 0);
        chk("coalesce_final", int'(digit), 4);

        // pixel decode
        pix_x = 10'(OX + 11); pix_y = 10'(OY + 17); tick();
        chk("pix_gx", int'(glyph_x), 1);
        chk("pix_gy", int'(glyph_y), 2);
        chk("pix_dig", int'(digit), 0);
        chk("pix_in", int'(in_digit), int'(!BLANK));
        pix_x = 10'(OX + 24); tick();
        chk("pix_gap", int'(in_digit), 0);
        pix_x = 10'(OX + 11); pix_y = 10'(OY + 40); tick();
        chk("pix_below", int'(in_digit), 0);
        chk("pix_below_gy", int'(glyph_y), 0);

        // clear/add collision and reset during SHIFT
        clear_score = 1'b1; add_valid = 1'b1; lines_cleared = 3'd4;
        tick();
        clear_score = 1'b0; add_valid = 1'b0;
        chk("clear_beats_add", int'(score), 0);
        wait_quiet();
        add(4);
        repeat (5) tick();
        chk("busy_in_shift", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_score", int'(score), 0);
        @(posedge clk); #1 reset = 1'b0;
        set_pix(12, 0);
        repeat (20) tick();
        chk("rst_disp_zero", int'(digit), 0);
        chk("rst_no_conv", int'(busy), 0);

        // leading-zero blanking
        for (int i = 0; i < 4; i++) begin
            set_pix(4 * i, 0); tick();
            chk("zero_in_digit", int'(in_digit), (BLANK && i < 3) ? 0 : 1);
        end
        add_valid = 1'b1; lines_cleared = 3'd4;
        repeat (38) tick();
        lines_cleared = 3'd1; tick();
        add_valid = 1'b0;
        chk("score_305", int'(score), 305);
        wait_quiet();
        set_pix(0, 0); tick();
        chk("d305_lead_in", int'(in_digit), int'(!BLANK));
        set_pix(4, 0); tick();
        chk("d305_3", int'(digit), 3);
        chk("d305_3_in", int'(in_digit), 1);
        set_pix(8, 0); tick();
        chk("d305_0", int'(digit), 0);
        chk("d305_0_in", int'(in_digit), 1);
        set_pix(12, 4); tick();
        chk("d305_5", int'(digit), 5);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            add_valid     = ($urandom_range(0, 5) == 0);
            lines_cleared = 3'($urandom_range(0, 7));
            clear_score   = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 9) == 0) begin
                pix_x = 10'($urandom);
                pix_y = 10'($urandom);
            end else begin
                pix_x = 10'(OX - 16 + $urandom_range(0, 160));
                pix_y = 10'(OY - 8 + $urandom_range(0, 56));
            end
            tick();
        end
        add_valid = 1'b0; clear_score = 1'b0;
        wait_quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_digit_feeder.md
# score_digit_feeder

Upstream feeder for the on-screen score glyph renderer. It holds the game score as a saturating binary counter and converts it to BCD with a sequential shift-add-3 engine. For every VGA pixel it outputs which decimal digit, and which glyph cell (x 0..2, y 0..4), that pixel falls in. Its digit/x/y outputs drive the 3x5 digit-shape lookup directly; `in_digit` gates the lookup's colour onto the pixel stream.

## Interface

Parameters:
- `DIGITS`, 4: number of displayed decimal digits; index 0 is leftmost (most significant).
- `SCORE_W`, 14: binary score width; must hold 10^DIGITS − 1.
- `ORIGIN_X`, 400: screen x of the score field's left edge.
- `ORIGIN_Y`, 40: screen y of the score field's top edge.
- `SCALE_LOG2`, 3: each glyph cell is 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.

Ports:
- `clk` in 1: system/pixel clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `add_valid` in 1: one-cycle pulse; adds points for `lines_cleared`.
- `lines_cleared` in 3: number of rows cleared (0..4), sampled when `add_valid` is high.
- `clear_score` in 1: synchronous score clear (new game).
- `pix_x` in 10: current pixel column.
- `pix_y` in 10: current pixel row.
- `score` out SCORE_W: binary score.
- `busy` out 1: BCD conversion in progress.
- `digit` out 4: BCD value of the digit under the pixel; 0 when not in the field.
- `glyph_x` out 3: cell column within the glyph, 0..2.
- `glyph_y` out 3: cell row within the glyph, 0..4.
- `in_digit` out 1: pixel lies on a glyph cell of a displayed digit.

## Operation

- **Points table.** `lines_cleared` 0/1/2/3/4 → 0/1/3/5/8. Values 5..7 add 0.
- **Score update.** On `add_valid`, `score` ← min(score + points, 10^DIGITS − 1). The sum is computed at SCORE_W+1 bits and then saturated.
- **`clear_score` priority.** It beats `add_valid` in the same cycle: score ← 0 and a conversion is requested.
- **Conversion FSM.**
  - States: IDLE → LOAD → SHIFT (SCORE_W cycles) → COMMIT → IDLE.
  - LOAD snapshots `score` into the shift register.
  - Each SHIFT cycle adds 3 to every BCD nibble ≥ 5, then shifts left 1.
  - COMMIT copies the result into the display BCD register `disp_bcd`.
- **Display register stability.** `disp_bcd` changes only in COMMIT, so the renderer never sees partial values.
- **Conversion requests.**
  - Any score change (add with nonzero points, or clear) sets `pending`.
  - From IDLE, a set `pending` moves the FSM to LOAD and clears `pending`.
  - A score change while the FSM is busy sets `pending` again, so one more conversion follows COMMIT. Updates are never lost; back-to-back adds coalesce.
- **`busy`.** High in LOAD, SHIFT and COMMIT.
- **Pixel decode.**
  - `u = (pix_x − ORIGIN_X) >> SCALE_LOG2` and `v = (pix_y − ORIGIN_Y) >> SCALE_LOG2`.
  - Field extent: pix_x ≥ ORIGIN_X, pix_y ≥ ORIGIN_Y, u < 4·DIGITS, v < 5.
  - Digit index = u / 4; `glyph_x` = u mod 4; `glyph_y` = v.
  - Column u mod 4 = 3 is the inter-digit gap: `in_digit` = 0 there.
  - Outside the field: `in_digit` = 0 and `digit`, `glyph_x`, `glyph_y` = 0.
- **Reset.** Asserting `reset` at any time forces:
  - `score` = 0 and FSM = IDLE;
  - `disp_bcd` = all zeros and `pending` = 0;
  - all outputs 0 (including `busy`);
  - any in-flight conversion is abandoned.

## Timing

- `score` updates on the clock edge after `add_valid`/`clear_score` (1-cycle latency).
- Conversion takes 1 (LOAD) + SCORE_W + 1 (COMMIT) cycles. With the default SCORE_W = 14 that is 16 cycles, so `disp_bcd` is valid 17 cycles after the score edge when the FSM was idle.
- Pixel outputs (`digit`, `glyph_x`, `glyph_y`, `in_digit`) are registered: 1-cycle latency from `pix_x`/`pix_y`. The pixel path is independent of the FSM.
- No handshake on `add_valid`: it is accepted on every cycle, including while busy.

## Configuration

- `SCORE_BLANK_LEADING_ZERO_EN` defined:
  - Leading-zero digits (every index left of the first nonzero digit) are blanked: `in_digit` = 0 on them.
  - The rightmost digit always shows, so a score of 0 displays a single "0".
  - The blank mask is derived from `disp_bcd` and registered alongside it.
- Macro undefined: all DIGITS positions always display, including leading zeros.

## Structure

- Package `score_pkg` holds:
  - the points-table function;
  - the `DIGITS`/`SCORE_W` defaults and the `SCORE_MAX` constant;
  - glyph geometry constants (cell width 4, glyph width 3, height 5);
  - the FSM state enum.
- Sub-module `bin2bcd_seq` contains the LOAD/SHIFT/COMMIT engine. Its interface:
  - inputs: start, bin;
  - outputs: bcd, busy, done.
- The top level holds the score register, the `pending` flag and the pixel decode.

## Test plan

- **Points and conversion:** reset, then `add_valid` with lines = 4 three times → `score` = 24; 17 cycles after the last add, pixel at field x = u·8 for u = 12 returns `digit` = 4, and u = 8 returns `digit` = 2.
- **Saturation:** preload to 9995 (repeated adds), then add lines = 4 → `score` = 9999, and after conversion every digit reads 9.
- **Coalescing:** add lines = 1 and, 5 cycles later during `busy`, add lines = 2 → a second conversion runs back-to-back and the final `disp_bcd` = 0004. `disp_bcd` never shows an intermediate value other than 0001.
- **Pixel decode:** pix = (ORIGIN_X + 11, ORIGIN_Y + 17) → digit index 0, `glyph_x` = 1, `glyph_y` = 2, `in_digit` = 1. pix_x = ORIGIN_X + 24 (gap column) → `in_digit` = 0. pix_y = ORIGIN_Y + 40 → `in_digit` = 0.
- **Clear/add collision and mid-conversion reset:** `clear_score` together with `add_valid` → `score` = 0. Asserting `reset` during SHIFT → `busy` = 0 immediately and `disp_bcd` = 0.
- **Leading-zero blanking (macro on):** score 0 → only the rightmost digit has `in_digit` = 1. Score 305 → the leftmost digit is blanked and the other three show 3, 0, 5.
